// File: rtl/ram_write_ctrl_if.sv
// Valid/ready byte stream into the RAM write controller.
// master = producer, slave = controller.
interface ram_write_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/ram_write_ctrl.sv
// Stream-to-RAM write controller: MATRIX_SIZE beats -> BASE_ADDR upward.
// Optional byte checksum under RAM_WRITE_CTRL_CHECKSUM_EN.
module ram_write_ctrl #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 32,
  parameter int                MATRIX_SIZE = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              start,
  ram_write_ctrl_if.slave   strm,
  output logic              busy,
  output logic              done,
  output logic              ram_clk,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rst_p,
  output logic [DATA_W-1:0] ram_wr,
  input  logic [DATA_W-1:0] ram_rd,
  output logic [15:0]       checksum
);

  localparam int CNT_W = $clog2(MATRIX_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MATRIX_SIZE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_q, wr_d;
  logic              accept;
  logic              take_start;

  assign accept     = (state_q == S_RECV) && strm.valid && ready_q;
  assign take_start = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    en_d    = en_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RECV;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end
      S_RECV: begin
        if (accept) begin
          wr_d   = strm.data;
          addr_d = BASE_ADDR + ADDR_W'(cnt_q);
          en_d   = 1'b1;
          we_d   = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            ready_d = 1'b0;
            state_d = S_LAST;
          end
        end else begin
          en_d = 1'b0;
          we_d = 1'b0;
        end
      end
      S_LAST: begin
        // final write is captured by the RAM on this edge
        en_d    = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (take_start) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q + 16'(strm.data);
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  logic unused_start;
  assign unused_start = take_start;
  assign checksum     = 16'h0000;
`endif

  logic unused_rd;
  assign unused_rd = ^ram_rd;

  assign strm.ready = ready_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign ram_clk    = clk;
  assign ram_rst_p  = rst_p;
  assign ram_en     = en_q;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_wr     = wr_q;

endmodule
